dest_id_matcher: RTL and testbench
==================================

// Module: dest_id_matcher
// PURPOSE
//  Multi-ID destination filter for a network node: decides whether an incoming packet's destinationID
//  addresses this node by scanning a programmable table of N_IDS node IDs (each with a don't-care mask),
//  plus an optional broadcast ID. Reports hit, broadcast flag and matching table index.
//  Sits between packet header decode and the local delivery / forward path.
//  Keeps the start/done/en handshake of the existing single-ID check.
// PARAMETERS
//  WORD_WIDTH    16       width of node IDs and destinationID
//  N_IDS         4        table entries, 1..16
//  IDX_W         2        index width, = max(1, clog2(N_IDS))
//  BCAST_EN      1        1: BROADCAST_ID matches unconditionally; 0: no broadcast check
//  BROADCAST_ID  16'hFFFF broadcast destination value
//  DEFAULT_ID    16'h0000 value loaded into entry 0 at reset; entry 0 resets valid
// PORTS
//  clock          in   1           system clock, rising edge
//  nrst           in   1           asynchronous active-low reset
//  en             in   1           acknowledge/arm: in WAIT, clears results and re-arms
//  start          in   1           begin a lookup; sampled only in IDLE
//  destinationID  in   WORD_WIDTH  destination under test; captured on accepted start
//  cfg_we         in   1           table write strobe
//  cfg_addr       in   IDX_W       entry to write
//  cfg_id         in   WORD_WIDTH  ID value to store
//  cfg_mask       in   WORD_WIDTH  compare mask; 1 = bit compared, 0 = don't care
//  cfg_valid      in   1           entry valid bit to store
//  cfg_ready      out  1           1 when writes are accepted (state IDLE or WAIT)
//  iamDestination out  1           hit (table or broadcast); valid while done=1
//  isBroadcast    out  1           hit was the broadcast ID
//  matchIndex     out  IDX_W       lowest matching entry; 0 on miss or broadcast
//  busy           out  1           1 in SCAN or DONE
//  done           out  1           result valid; held until en accepted in WAIT
// BEHAVIOUR
//  Reset (async, nrst=0): state=WAIT; iamDestination=0, isBroadcast=0, matchIndex=0, done=0, busy=0;
//   table: entry0 = {DEFAULT_ID, mask all-ones, valid=1}; others = {0, all-ones, valid=0}.
//   Reset mid-scan aborts the lookup; no partial result survives.
//  FSM, registered, one transition per rising clock:
//   WAIT : en=1 -> clear iamDestination/isBroadcast/matchIndex/done, -> IDLE; else stay. start ignored.
//   IDLE : start=1 -> capture destinationID into dest_q, idx=0, -> SCAN; else stay.
//   SCAN : first cycle only: BCAST_EN && dest_q==BROADCAST_ID -> iamDestination=1, isBroadcast=1, -> DONE.
//          Otherwise compare entry idx: hit = valid && (((id ^ dest_q) & mask) == 0).
//          hit -> iamDestination=1, matchIndex=idx, -> DONE.
//          miss, idx==N_IDS-1 -> iamDestination=0, -> DONE. Otherwise idx++.
//   DONE : done=1 -> WAIT.
//  Latency, counted from the edge that samples start in IDLE:
//   done rises after 3 edges for a broadcast or entry-0 hit; after 3+i edges for an entry-i hit;
//   after 2+N_IDS edges on a miss.
//  Scan is lowest-index-first with early exit, so the lowest matching index is reported.
//  en outside WAIT is ignored. start outside IDLE is ignored (no queueing).
//  en and start together in WAIT: en is taken, start dropped; the next lookup needs start in IDLE.
//  Config: write is applied at the clock edge when cfg_we && cfg_ready && cfg_addr<N_IDS; otherwise dropped silently.
//   cfg_ready=0 in SCAN/DONE, so the table is stable for the whole scan.
//   Writes in IDLE take effect for the next lookup.
//  Mask all-zeros on a valid entry matches every destination.
//  Invalid entries never match.
//  All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared include/package: WORD_WIDTH define; FSM state encodings (WAIT=3, IDLE=0, SCAN=1, DONE=2)
//   as localparams, shared with other handshake blocks.
//  Sub-module node_id_table: N_IDS x {id, mask, valid} register file with async reset,
//   write port and combinational read mux by idx.
//  The top level holds the FSM, dest_q, idx counter and result registers.
// TESTING
//  1 Reset, no en/start for 10 cycles -> done=0, iamDestination=0; then en, then start with
//    dest=16'h0000 -> done after 3 edges, iamDestination=1, matchIndex=0.
//  2 Write entry2={16'h1230, mask 16'hFFF0, valid}; dest=16'h123A -> hit, matchIndex=2,
//    done after 5 edges; dest=16'h124A -> miss, done after 6 edges (N_IDS=4).
//  3 dest=16'hFFFF with BCAST_EN=1 -> iamDestination=1, isBroadcast=1, matchIndex=0, done after 3 edges;
//    BCAST_EN=0 with no table hit -> miss.
//  4 Entries 1 and 3 both match -> matchIndex=1. cfg_we during SCAN to entry 3 -> dropped,
//    entry 3 unchanged on readback lookup.
//  5 Hold en=0 after done -> done/iamDestination held for 20 cycles; start in WAIT ignored;
//    en+start same cycle -> IDLE, no lookup.
//  6 Assert nrst low mid-SCAN (async, between edges) -> outputs 0 immediately, state WAIT,
//    table back to reset contents.

Source files
------------

// File: rtl/dest_id_matcher_pkg.sv
// Shared definitions for the destination-ID filter and its sibling handshake blocks.
// The state encodings are fixed values because other handshake blocks decode them too.
package dest_id_matcher_pkg;

  localparam int DIM_WORD_WIDTH = 16;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_SCAN_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;
  localparam logic [1:0] ST_WAIT_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_SCAN = ST_SCAN_ENC,
    ST_DONE = ST_DONE_ENC,
    ST_WAIT = ST_WAIT_ENC
  } state_t;

endpackage

// File: rtl/dest_id_matcher_node_id_table.sv
// Register file of node IDs, each with a compare mask and a valid bit.
// Entry 0 comes out of reset holding the default node ID so a freshly reset
// node still recognises its own address; every other entry resets invalid.
module node_id_table
  import dest_id_matcher_pkg::*;
#(
  parameter int                    WORD_WIDTH = DIM_WORD_WIDTH,
  parameter int                    N_IDS      = 4,
  parameter int                    IDX_W      = 2,
  parameter logic [WORD_WIDTH-1:0] DEFAULT_ID = '0
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_id,
  input  logic [WORD_WIDTH-1:0] wr_mask,
  input  logic                  wr_valid,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [WORD_WIDTH-1:0] rd_id,
  output logic [WORD_WIDTH-1:0] rd_mask,
  output logic                  rd_valid
);

  logic [WORD_WIDTH-1:0] id_mem   [N_IDS];
  logic [WORD_WIDTH-1:0] mask_mem [N_IDS];
  logic [N_IDS-1:0]      valid_mem;

  // Table storage: reset image, then single-entry writes; out-of-range addresses are dropped
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < N_IDS; i++) begin
        id_mem[i]    <= (i == 0) ? DEFAULT_ID : '0;
        mask_mem[i]  <= '1;
        valid_mem[i] <= (i == 0);
      end
    end else if (wr_en && (int'(wr_addr) < N_IDS)) begin
      id_mem[wr_addr]    <= wr_id;
      mask_mem[wr_addr]  <= wr_mask;
      valid_mem[wr_addr] <= wr_valid;
    end
  end

  // Read mux for the entry currently being scanned; unused index codes read as an invalid entry
  always_comb begin
    rd_id    = '0;
    rd_mask  = '0;
    rd_valid = 1'b0;
    if (int'(rd_idx) < N_IDS) begin
      rd_id    = id_mem[rd_idx];
      rd_mask  = mask_mem[rd_idx];
      rd_valid = valid_mem[rd_idx];
    end
  end

endmodule

// File: rtl/dest_id_matcher.sv
// Multi-ID destination filter. A lookup captures the destination, checks the
// broadcast ID once, then walks the ID table lowest index first and stops at the
// first hit, so the reported index is always the lowest matching entry.
// The result is held with done=1 until en acknowledges it.
module dest_id_matcher
  import dest_id_matcher_pkg::*;
#(
  parameter int                    WORD_WIDTH   = DIM_WORD_WIDTH,
  parameter int                    N_IDS        = 4,
  parameter int                    IDX_W        = 2,
  parameter bit                    BCAST_EN     = 1'b1,
  parameter logic [WORD_WIDTH-1:0] BROADCAST_ID = '1,
  parameter logic [WORD_WIDTH-1:0] DEFAULT_ID   = '0
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] destinationID,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_addr,
  input  logic [WORD_WIDTH-1:0] cfg_id,
  input  logic [WORD_WIDTH-1:0] cfg_mask,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  iamDestination,
  output logic                  isBroadcast,
  output logic [IDX_W-1:0]      matchIndex,
  output logic                  busy,
  output logic                  done
);

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] dest_q, dest_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  iam_q, iam_d;
  logic                  bcast_q, bcast_d;
  logic [IDX_W-1:0]      match_q, match_d;
  logic                  done_q, done_d;

  logic [WORD_WIDTH-1:0] entry_id;
  logic [WORD_WIDTH-1:0] entry_mask;
  logic                  entry_valid;
  logic                  entry_hit;
  logic                  bcast_hit;
  logic                  idx_last;
  logic                  table_open;

  // The table only accepts writes while no lookup is in flight, keeping it stable during a scan
  assign table_open = (state_q == ST_IDLE) || (state_q == ST_WAIT);

  node_id_table #(
    .WORD_WIDTH (WORD_WIDTH),
    .N_IDS      (N_IDS),
    .IDX_W      (IDX_W),
    .DEFAULT_ID (DEFAULT_ID)
  ) u_table (
    .clock    (clock),
    .nrst     (nrst),
    .wr_en    (cfg_we && table_open),
    .wr_addr  (cfg_addr),
    .wr_id    (cfg_id),
    .wr_mask  (cfg_mask),
    .wr_valid (cfg_valid),
    .rd_idx   (idx_q),
    .rd_id    (entry_id),
    .rd_mask  (entry_mask),
    .rd_valid (entry_valid)
  );

  // Match terms for the current scan step; broadcast is only considered on the first step (idx 0)
  always_comb begin
    entry_hit = entry_valid && (((entry_id ^ dest_q) & entry_mask) == '0);
    bcast_hit = BCAST_EN && (idx_q == '0) && (dest_q == BROADCAST_ID);
    idx_last  = (int'(idx_q) == (N_IDS - 1));
  end

  // Next-state and result logic for the WAIT -> IDLE -> SCAN -> DONE handshake
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    idx_d   = idx_q;
    iam_d   = iam_q;
    bcast_d = bcast_q;
    match_d = match_q;
    done_d  = done_q;
    case (state_q)
      ST_WAIT: begin
        if (en) begin
          iam_d   = 1'b0;
          bcast_d = 1'b0;
          match_d = '0;
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (start) begin
          dest_d  = destinationID;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (bcast_hit) begin
          iam_d   = 1'b1;
          bcast_d = 1'b1;
          state_d = ST_DONE;
        end else if (entry_hit) begin
          iam_d   = 1'b1;
          match_d = idx_q;
          state_d = ST_DONE;
        end else if (idx_last) begin
          iam_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // State and result registers; reset aborts any lookup and lands in WAIT with results cleared
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_WAIT;
      dest_q  <= '0;
      idx_q   <= '0;
      iam_q   <= 1'b0;
      bcast_q <= 1'b0;
      match_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      idx_q   <= idx_d;
      iam_q   <= iam_d;
      bcast_q <= bcast_d;
      match_q <= match_d;
      done_q  <= done_d;
    end
  end

  assign cfg_ready      = table_open;
  assign busy           = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign iamDestination = iam_q;
  assign isBroadcast    = bcast_q;
  assign matchIndex     = match_q;
  assign done           = done_q;

endmodule

// File: tb/tb_dest_id_matcher.sv
// Bench for dest_id_matcher. Two instances share every input: one with the
// broadcast check enabled and one without. Each lookup pushes the expected
// result and latency for both; per-instance monitors pop and compare on done rising.
module tb_dest_id_matcher;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct {
    logic          hit;
    logic          bc;
    logic [IW-1:0] idx;
    int            lat;
    int            startCyc;
  } exp_t;

  logic          clock = 1'b0;
  logic          nrst  = 1'b0;
  logic          en    = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  destinationID = '0;
  logic          cfg_we    = 1'b0;
  logic [IW-1:0] cfg_addr  = '0;
  logic [W-1:0]  cfg_id    = '0;
  logic [W-1:0]  cfg_mask  = '0;
  logic          cfg_valid = 1'b0;

  logic          cfgReady, iam, bc, busy, done;
  logic [IW-1:0] mi;
  logic          nbCfgReady, nbIam, nbBc, nbBusy, nbDone;
  logic [IW-1:0] nbMi;

  exp_t expQ[$];
  exp_t nbQ[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  dest_id_matcher #(
    .WORD_WIDTH(W), .N_IDS(N), .IDX_W(IW), .BCAST_EN(1'b1),
    .BROADCAST_ID(16'hFFFF), .DEFAULT_ID(16'h0000)
  ) dut (
    .clock(clock), .nrst(nrst), .en(en), .start(start),
    .destinationID(destinationID), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_id(cfg_id), .cfg_mask(cfg_mask), .cfg_valid(cfg_valid),
    .cfg_ready(cfgReady), .iamDestination(iam), .isBroadcast(bc),
    .matchIndex(mi), .busy(busy), .done(done)
  );

  dest_id_matcher #(
    .WORD_WIDTH(W), .N_IDS(N), .IDX_W(IW), .BCAST_EN(1'b0),
    .BROADCAST_ID(16'hFFFF), .DEFAULT_ID(16'h0000)
  ) dutNb (
    .clock(clock), .nrst(nrst), .en(en), .start(start),
    .destinationID(destinationID), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_id(cfg_id), .cfg_mask(cfg_mask), .cfg_valid(cfg_valid),
    .cfg_ready(nbCfgReady), .iamDestination(nbIam), .isBroadcast(nbBc),
    .matchIndex(nbMi), .busy(nbBusy), .done(nbDone)
  );

  always #5 clock = ~clock;

  // Edge counter used to measure start-to-done latency
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor for the broadcast-enabled instance
  logic prevDone = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (done && !prevDone) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", done, 1'b0);
      end else begin
        e = expQ.pop_front();
        checkOutput("iamDestination", iam, e.hit);
        checkOutput("isBroadcast", bc, e.bc);
        checkOutput("matchIndex", mi, e.idx);
        checkOutput("latency", cyc - e.startCyc, e.lat);
      end
    end
    prevDone = done;
  end

  // Monitor for the broadcast-disabled instance
  logic nbPrevDone = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (nbDone && !nbPrevDone) begin
      if (nbQ.size() == 0) begin
        checkOutput("nb_unexpected_done", nbDone, 1'b0);
      end else begin
        e = nbQ.pop_front();
        checkOutput("nb_iamDestination", nbIam, e.hit);
        checkOutput("nb_isBroadcast", nbBc, e.bc);
        checkOutput("nb_matchIndex", nbMi, e.idx);
        checkOutput("nb_latency", cyc - e.startCyc, e.lat);
      end
    end
    nbPrevDone = nbDone;
  end

  // All stimulus tasks are entered and left just after a falling edge
  task automatic applyStimulus(input logic [W-1:0] dest,
                               input logic hit, input logic isBc, input int idx, input int lat,
                               input logic nbHit, input int nbIdx, input int nbLat);
    exp_t e;
    destinationID = dest;
    start = 1'b1;
    e.hit = hit; e.bc = isBc; e.idx = IW'(idx); e.lat = lat; e.startCyc = cyc;
    expQ.push_back(e);
    e.hit = nbHit; e.bc = 1'b0; e.idx = IW'(nbIdx); e.lat = nbLat; e.startCyc = cyc;
    nbQ.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitBoth();
    int k = 0;
    while (!(done && nbDone) && k < 40) begin
      @(negedge clock);
      k++;
    end
    checkOutput("done_reached", done && nbDone, 1'b1);
  endtask

  task automatic ack();
    en = 1'b1;
    @(negedge clock);
    en = 1'b0;
  endtask

  task automatic cfgWrite(input int addr, input logic [W-1:0] id, input logic [W-1:0] mask, input logic v);
    cfg_we = 1'b1; cfg_addr = IW'(addr); cfg_id = id; cfg_mask = mask; cfg_valid = v;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic lookup(input logic [W-1:0] dest,
                        input logic hit, input logic isBc, input int idx, input int lat,
                        input logic nbHit, input int nbIdx, input int nbLat);
    applyStimulus(dest, hit, isBc, idx, lat, nbHit, nbIdx, nbLat);
    waitBoth();
    ack();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset, then idle with no en/start
    repeat (3) @(negedge clock);
    nrst = 1'b1;
    repeat (10) @(negedge clock);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_iam", iam, 1'b0);
    checkOutput("rst_bc", bc, 1'b0);
    checkOutput("rst_mi", mi, 2'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_cfg_ready", cfgReady, 1'b1);
    ack();
    lookup(16'h0000, 1, 0, 0, 3, 1, 0, 3);

    // Masked entry: hit on low-nibble don't-care, miss on a changed compared bit
    cfgWrite(2, 16'h1230, 16'hFFF0, 1'b1);
    lookup(16'h123A, 1, 0, 2, 5, 1, 2, 5);
    lookup(16'h124A, 0, 0, 0, 6, 0, 0, 6);

    // Broadcast: only the enabled instance treats it as a hit
    lookup(16'hFFFF, 1, 1, 0, 3, 0, 0, 6);

    // Two matching entries: lowest index wins
    cfgWrite(1, 16'h5500, 16'hFF00, 1'b1);
    cfgWrite(3, 16'h55AA, 16'hFFFF, 1'b1);
    lookup(16'h55AA, 1, 0, 1, 4, 1, 1, 4);

    // Write attempted during SCAN is dropped
    applyStimulus(16'h7777, 0, 0, 0, 6, 0, 0, 6);
    checkOutput("scan_cfg_ready", cfgReady, 1'b0);
    checkOutput("scan_busy", busy, 1'b1);
    cfgWrite(3, 16'h7777, 16'hFFFF, 1'b1);
    waitBoth();
    ack();
    lookup(16'h7777, 0, 0, 0, 6, 0, 0, 6);

    // Invalid entry 0 never matches; all-zero mask on valid entry 3 matches anything
    cfgWrite(0, 16'h0000, 16'hFFFF, 1'b0);
    cfgWrite(3, 16'h0000, 16'h0000, 1'b1);
    lookup(16'hABCD, 1, 0, 3, 6, 1, 3, 6);
    lookup(16'h0000, 1, 0, 3, 6, 1, 3, 6);
    lookup(16'hFFFF, 1, 1, 0, 3, 1, 3, 6);

    // Result held while en stays low; start in WAIT ignored
    applyStimulus(16'h55AA, 1, 0, 1, 4, 1, 1, 4);
    waitBoth();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checkOutput("hold_done", done, 1'b1);
      checkOutput("hold_iam", iam, 1'b1);
    end
    checkOutput("hold_mi", mi, 2'd1);
    start = 1'b1;
    destinationID = 16'h1235;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("wait_start_busy", busy, 1'b0);
      checkOutput("wait_start_done", done, 1'b1);
    end
    // en and start together: en taken, start dropped
    en = 1'b1;
    start = 1'b1;
    @(negedge clock);
    en = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("enstart_busy", busy, 1'b0);
      checkOutput("enstart_done", done, 1'b0);
      checkOutput("enstart_iam", iam, 1'b0);
    end
    lookup(16'h1235, 1, 0, 2, 5, 1, 2, 5);

    // Asynchronous reset in the middle of a scan
    applyStimulus(16'hABCD, 1, 0, 3, 6, 1, 3, 6);
    @(posedge clock);
    #2;
    checkOutput("prerst_busy", busy, 1'b1);
    nrst = 1'b0;
    #1;
    checkOutput("async_busy", busy, 1'b0);
    checkOutput("async_nb_busy", nbBusy, 1'b0);
    checkOutput("async_done", done, 1'b0);
    checkOutput("async_iam", iam, 1'b0);
    checkOutput("async_cfg_ready", cfgReady, 1'b1);
    expQ.delete();
    nbQ.delete();
    @(negedge clock);
    nrst = 1'b1;
    @(negedge clock);
    checkOutput("postrst_done", done, 1'b0);
    ack();
    // Table back to reset image: entry 0 valid default, entries 1..3 invalid
    lookup(16'h0000, 1, 0, 0, 3, 1, 0, 3);
    lookup(16'h55AA, 0, 0, 0, 6, 0, 0, 6);
    lookup(16'hABCD, 0, 0, 0, 6, 0, 0, 6);

    checkOutput("queue_drained", expQ.size() + nbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
